// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - registered valid/ready pipeline stage with 2-entry skid buffer, flush and ctrl bubble gating
// Optional stall counter output enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_skid #(
  parameter int CTRL_W = 5,
  parameter int DATA_W = 102
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  logic              main_v, skid_v, in_ready_q;
  logic              main_v_n, skid_v_n;
  logic              load_main_in, load_main_skid, load_skid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              accept, pop;

  assign accept = in_valid & in_ready_q;
  assign pop    = main_v & out_ready;

  // State and payload registers; in_ready is the registered complement of the next skid_v.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v     <= 1'b0;
      skid_v     <= 1'b0;
      in_ready_q <= 1'b1;
      main_ctrl  <= '0;
      main_data  <= '0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else begin
      main_v     <= main_v_n;
      skid_v     <= skid_v_n;
      in_ready_q <= ~skid_v_n;
      if (load_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

  always_comb begin
    main_v_n       = main_v;
    skid_v_n       = skid_v;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      main_v_n = 1'b0;
      skid_v_n = 1'b0;
    end else begin
      case ({main_v, skid_v})
        2'b00: begin
          if (accept) begin
            main_v_n     = 1'b1;
            load_main_in = 1'b1;
          end
        end
        2'b10: begin
          if (accept && pop) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            skid_v_n  = 1'b1;
            load_skid = 1'b1;
          end else if (pop) begin
            main_v_n = 1'b0;
          end
        end
        2'b11: begin
          if (pop) begin
            skid_v_n       = 1'b0;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          // (0,1) is unreachable; fall back to EMPTY if it ever appears.
          main_v_n = 1'b0;
          skid_v_n = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    in_ready  = in_ready_q;
    out_valid = main_v;
    out_ctrl  = main_v ? main_ctrl : '0;
    out_data  = main_data;
    occupancy = {1'b0, main_v} + {1'b0, skid_v};
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (main_v && !out_ready && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - randomized self-checking bench for pipe_stage_skid against a queue model
module tb_pipe_stage_skid;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [4:0]   in_ctrl = '0;
  logic [101:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [4:0]   out_ctrl;
  logic [101:0] out_data;
  logic [1:0]   occupancy;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0]  stall_cnt;
  logic [15:0]  sc_model = '0;
`endif

  int checks = 0;
  int failures = 0;

  logic [4:0]   qc[$];
  logic [101:0] qd[$];

  pipe_stage_skid #(.CTRL_W(5), .DATA_W(102)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_ctrl(in_ctrl),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl(out_ctrl),
    .out_data(out_data),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input logic after_rst);
    int n;
    n = qd.size();
    check("out_valid", {127'd0, out_valid}, {127'd0, n > 0});
    check("in_ready", {127'd0, in_ready}, {127'd0, n < 2});
    check("occupancy", {126'd0, occupancy}, 128'(n));
    check("out_ctrl", {123'd0, out_ctrl}, (n > 0) ? {123'd0, qc[0]} : 128'd0);
    if (n > 0) check("out_data", {26'd0, out_data}, {26'd0, qd[0]});
    if (after_rst) check("rst_data", {26'd0, out_data}, 128'd0);
`ifdef PIPE_STAGE_STALL_CNT_EN
    check("stall_cnt", {112'd0, stall_cnt}, {112'd0, sc_model});
`endif
  endtask

  // Drive one cycle of inputs, advance the queue model across the edge, then check.
  task automatic cycle(input logic iv, input logic [4:0] c, input logic [101:0] d,
                       input logic ordy, input logic fl, input logic r);
    logic acc, pp;
    in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl; rst = r;
    acc = iv && (qd.size() < 2);
    pp  = ordy && (qd.size() > 0);
`ifdef PIPE_STAGE_STALL_CNT_EN
    if (r) sc_model = '0;
    else if (qd.size() > 0 && !ordy && sc_model != 16'hFFFF) sc_model = sc_model + 16'd1;
`endif
    @(posedge clk);
    if (r || fl) begin
      qc.delete();
      qd.delete();
    end else begin
      if (pp) begin
        void'(qc.pop_front());
        void'(qd.pop_front());
      end
      if (acc) begin
        qc.push_back(c);
        qd.push_back(d);
      end
    end
    #1;
    check_outputs(r);
  endtask

  initial begin
    logic [101:0] rd;
    // Reset then idle
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);
    // Streaming with downstream always ready
    cycle(1, 0, 102'h1, 1, 0, 0);
    cycle(1, 0, 102'h2, 1, 0, 0);
    cycle(1, 0, 102'h3, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    // Backpressure fill, ignored third push, ordered drain
    cycle(1, 0, 102'hA, 0, 0, 0);
    cycle(1, 0, 102'hB, 0, 0, 0);
    cycle(1, 0, 102'hC, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    // Flush while FULL with a competing push
    cycle(1, 5'h3, 102'h11, 0, 0, 0);
    cycle(1, 5'h4, 102'h12, 0, 0, 0);
    cycle(1, 5'h7, 102'hD, 0, 1, 0);
    cycle(0, 0, 0, 1, 0, 0);
    // Ctrl gating
    cycle(1, 5'b10101, 102'h5, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
`ifdef PIPE_STAGE_STALL_CNT_EN
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 5'h1, 102'h77, 0, 0, 0);
    for (int i = 0; i < 7; i++) cycle(0, 0, 0, 0, 0, 0);
    check("stall7", {112'd0, stall_cnt}, 128'd7);
    force dut.stall_cnt_q = 16'hFFFE;
    #1;
    release dut.stall_cnt_q;
    sc_model = 16'hFFFE;
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
    check("stall_sat", {112'd0, stall_cnt}, 128'hFFFF);
    cycle(0, 0, 0, 1, 0, 0);
`endif
    // Random traffic with occasional flush and reset
    for (int i = 0; i < 500; i++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      cycle(1'($urandom_range(0, 3) != 0), 5'($urandom), rd,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 63) == 0));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-width EX/MEM latch.
- Registered pipeline stage with valid/ready handshake, a 2-entry skid buffer (main + skid slot), flush, and bubble gating of control fields.
- Sits between any two datapath stages (EX→MEM first user). Lets the downstream stage stall without a combinational ready path back into the upstream stage.

Parameters:
- CTRL_W, 5: width of control bundle (wb+m fields); forced to zero when the stage is invalid.
- DATA_W, 102: width of data bundle (branch target, zero flag, ALU result, store data, dest reg).

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous reset, active-high.
- flush, input, 1: discard all held entries this cycle.
- in_valid, input, 1: upstream offers an entry.
- in_ready, output, 1: stage can accept an entry. Registered output.
- in_ctrl, input, CTRL_W: upstream control bundle.
- in_data, input, DATA_W: upstream data bundle.
- out_valid, output, 1: main slot holds a valid entry.
- out_ready, input, 1: downstream consumes this cycle.
- out_ctrl, output, CTRL_W: control bundle; all-zero whenever out_valid=0.
- out_data, output, DATA_W: data bundle of main slot.
- occupancy, output, 2: number of valid entries, 0..2.

Behaviour:
- Reset (rst=1 at posedge): main_v=0, skid_v=0, main/skid ctrl+data=0, in_ready=1, out_valid=0, out_ctrl=0, out_data=0, occupancy=0. Reset overrides flush and all handshakes, including mid-transfer.
- Handshake:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ctrl/in_data are sampled only on accept.
- State is encoded by (main_v, skid_v): EMPTY (0,0), ONE (1,0), FULL (1,1). (0,1) is illegal and must never occur.
- Transitions at posedge (no flush):
  - EMPTY, accept → ONE; main ← input.
  - ONE, accept & pop → ONE; main ← input.
  - ONE, accept & !pop → FULL; skid ← input, main unchanged.
  - ONE, !accept & pop → EMPTY.
  - ONE, no events → hold.
  - FULL, pop → ONE; main ← skid. No accept is possible because in_ready=0.
  - FULL, !pop → hold.
- in_ready is registered: in_ready = !skid_v for the next state. It is 1 in EMPTY/ONE and 0 in FULL. No combinational path from out_ready to in_ready.
- Latency:
  - Entry accepted at edge N is visible on out_* after edge N (1 cycle) when the stage was EMPTY, or when ONE with a simultaneous pop.
  - Strict FIFO order; no entry is duplicated or dropped except by flush.
- Flush (flush=1, rst=0):
  - Next state EMPTY, in_ready=1.
  - A same-cycle accept is discarded (flush wins).
  - A same-cycle pop still counts as consumed downstream.
  - Stored data registers may keep stale values; out_ctrl is 0 regardless.
- Bubble gating: out_ctrl = main_v ? main_ctrl : 0. out_data is not gated.
- occupancy = main_v + skid_v.
- Data/ctrl registers load only on the listed transitions; otherwise they hold.

Optional Feature:
- Macro PIPE_STAGE_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt, 16 bits, reset 0.
  - Increments each cycle with out_valid=1 & out_ready=0; saturates at 16'hFFFF.
  - Cleared by rst only (not by flush).
- Undefined: the stall_cnt port and its counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release → out_valid=0, in_ready=1, occupancy=0, out_ctrl=0.
- Streaming: out_ready=1; in_valid=1 with data 0x1, 0x2, 0x3 on consecutive cycles → out_data 0x1, 0x2, 0x3 one cycle later each, occupancy stays 1, in_ready stays 1.
- Backpressure fill: out_ready=0; push 0xA then 0xB → occupancy=2 and in_ready=0 after second edge. A third push of 0xC is ignored while in_ready=0. Then out_ready=1 → pops 0xA, 0xB in order; in_ready=1 after the first pop edge.
- Flush in FULL with in_valid=1 (data 0xD): next cycle occupancy=0, out_valid=0, out_ctrl=0, and 0xD never appears at the output.
- Ctrl gating: push ctrl=5'b10101 then drain → out_ctrl=5'b10101 while valid, 0 once out_valid=0.
- With PIPE_STAGE_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 7 cycles → stall_cnt=7. Preload near the limit (force 16'hFFFE, 3 stall cycles) → stall_cnt=16'hFFFF.
